reg_lock_arbiter: RTL and testbench
===================================

Name: reg_lock_arbiter

Overview:
- Shares the architectural register lock table between NUM_REQ issue-side grant checkers.
- Each cycle, it round-robin-grants one eligible requester and sets that requester's destination lock bits.
- It clears bits released by writeback and wipes the table on a pipeline flush (jump).
- It owns the single authoritative lock vector that all grant checkers read.

Parameters:
- NUM_REQ, 4, number of requesting grant checkers/issue lanes (2..8).
- NR, rv64g_pkg::NUM_REGS (64), lock table width. Bit 0 = x0, never lockable.

Ports:
- clk_i  input  1  clock.
- arst_ni  input  1  asynchronous active-low reset.
- req_i  input  NUM_REQ  per-requester arbitration request (arb_req from each checker).
- lock_set_i  input  NUM_REQ x NR  registers requester i locks if granted. Unpacked [NUM_REQ][NR].
- gnt_o  output  NUM_REQ  one-hot grant, combinational from current-cycle inputs and state.
- unlock_i  input  NR  registers released by writeback this cycle.
- flush_i  input  1  clear all locks; no grant this cycle.
- locks_o  output  NR  current lock table (registered).
- rr_ptr_o  output  $clog2(NUM_REQ)  current highest-priority requester index (debug/verif).

Behaviour:
- Reset (arst_ni=0, asynchronous):
  - locks_q=0 and rr_ptr=0.
  - gnt_o=0 while in reset.
  - Outputs are valid from the first clk_i edge after deassertion.
- Eligibility:
  - elig[i] = req_i[i] & ~|(lock_set_i[i] & locks_q & ~unlock_i).
  - A register being unlocked this cycle counts as free.
- Grant:
  - Combinational, zero-cycle latency.
  - Winner is the first elig index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - gnt_o is one-hot or zero. Never more than one bit set.
- flush_i=1 forces gnt_o=0 regardless of req_i.
- Pointer update at posedge:
  - If a grant occurs, rr_ptr <= (winner+1) mod NUM_REQ.
  - Otherwise rr_ptr holds. It also holds on flush.
  - Wrap from NUM_REQ-1 to 0.
- Lock table next state:
  - Flush: locks_q <= 0. Flush dominates unlock and set.
  - Otherwise: locks_q <= (locks_q & ~unlock_i) | (grant ? lock_set_i[winner] : 0).
  - Bit 0 is always forced to 0.
- Simultaneous unlock_i[r] and winner set of r (new producer): the bit ends at 1.
- unlock_i of an already-clear bit is a no-op, with no error.
- No requests or no eligible requests: gnt_o=0, locks_q updates only by unlock_i.
- Requesters must hold req_i and lock_set_i stable until granted. Arbiter state does not depend on withdrawn requests.
- Reset mid-operation: all locks are dropped immediately. The upstream pipeline is assumed flushed by the same reset.

Optional Feature:
- Macro REG_LOCK_PERF_EN.
- When defined, the block adds output conflict_cnt_o (32 bits).
  - It is a saturating counter of cycles with popcount(req_i)>=2, or req_i!=0 with no grant (excluding flush cycles).
  - Reset to 0, saturates at 32'hFFFF_FFFF.
- When undefined, the port and counter are absent. Functional behaviour is otherwise identical.

Test Plan:
- Reset then idle: arst_ni low 3 cycles, release, req_i=0 -> locks_o=0, gnt_o=0, rr_ptr_o=0 every cycle.
- Round-robin fairness:
  - Stimulus: req_i=4'b1111 held, lock_set_i[i]=1<<(i+1), unlock_i mirrors previous grant.
  - Required response: gnt_o sequence 0001,0010,0100,1000,0001; rr_ptr_o 0,1,2,3,0.
- WAW blocking:
  - Stimulus: locks_o has bit 5 set; req_i=4'b0011, lock_set_i[0]=bit5, lock_set_i[1]=bit6, rr_ptr=0.
  - Required response: gnt_o=0010; next locks_o has bits 5 and 6 set.
- Unlock/set same cycle:
  - Stimulus: locks_o has bit 7 set; unlock_i has bit 7 set; req_i[2]=1 with lock_set_i[2]=bit7.
  - Required response: gnt_o=0100 granted same cycle; next locks_o bit 7 = 1.
- Flush priority: locks_o=64'hF0; flush_i=1 with req_i=4'b1111 and unlock_i=0 -> gnt_o=0, next locks_o=0, rr_ptr_o unchanged.
- x0 immunity: lock_set_i[0]=64'h1, req_i=0001 -> gnt_o=0001, locks_o bit0 stays 0.
- With REG_LOCK_PERF_EN: 10 cycles of req_i=4'b0011 -> conflict_cnt_o=10.

Source files
------------

// File: rtl/reg_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_lock_arbiter
// Purpose  : Round-robin arbiter that owns the shared register lock table for
//            the issue-side grant checkers. Optional macro: REG_LOCK_PERF_EN
//            adds a saturating conflict counter output.
// Revision : 1.0 - initial release
// ============================================================================
module reg_lock_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NR      = 64
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NR-1:0]                lock_set_i [NUM_REQ],
    output logic [NUM_REQ-1:0]           gnt_o,
    input  logic [NR-1:0]                unlock_i,
    input  logic                         flush_i,
    output logic [NR-1:0]                locks_o,
    output logic [$clog2(NUM_REQ)-1:0]   rr_ptr_o
`ifdef REG_LOCK_PERF_EN
    ,
    output logic [31:0]                  conflict_cnt_o
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    logic [NR-1:0]      locks_q, locks_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [PW-1:0]      winner;
    logic               grant;

    // A register released by writeback this cycle already counts as free.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_i[i] & ~|(lock_set_i[i] & locks_q & ~unlock_i);
        end
    end

    always_comb begin
        logic [PW:0] sum;
        sum    = '0;
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            if (!found && elig[sum[PW-1:0]]) begin
                found  = 1'b1;
                winner = sum[PW-1:0];
            end
        end
    end

    assign grant = found & ~flush_i & arst_ni;

    always_comb begin
        gnt_o = '0;
        if (grant) begin
            gnt_o[winner] = 1'b1;
        end
    end

    always_comb begin
        locks_d  = locks_q;
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            locks_d = '0;
        end else begin
            locks_d = locks_q & ~unlock_i;
            if (grant) begin
                locks_d  = locks_d | lock_set_i[winner];
                rr_ptr_d = (winner == PW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
            end
        end
        locks_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            locks_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            locks_q  <= locks_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign locks_o  = locks_q;
    assign rr_ptr_o = rr_ptr_q;

`ifdef REG_LOCK_PERF_EN
    logic [31:0] cnt_q, cnt_d;
    logic        conflict;

    // Contention: several requesters at once, or someone waiting with no winner.
    assign conflict = ~flush_i & (($countones(req_i) >= 2) | ((|req_i) & ~found));

    always_comb begin
        cnt_d = cnt_q;
        if (conflict && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_lock_arbiter
// Purpose  : Directed and random checks of reg_lock_arbiter against a
//            per-register reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_lock_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         arst_n;
    logic [N-1:0] req;
    logic [63:0]  ls [N];
    logic [N-1:0] gnt;
    logic [63:0]  unlock;
    logic         flush;
    logic [63:0]  locks;
    logic [1:0]   rr_ptr;
`ifdef REG_LOCK_PERF_EN
    logic [31:0]  conflict_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bit          m_lock [64];
    int          m_ptr;
    longint      m_cnt;
    logic [N-1:0] obs_gnt;

    reg_lock_arbiter #(.NUM_REQ(N), .NR(64)) dut (
        .clk_i      (clk),
        .arst_ni    (arst_n),
        .req_i      (req),
        .lock_set_i (ls),
        .gnt_o      (gnt),
        .unlock_i   (unlock),
        .flush_i    (flush),
        .locks_o    (locks),
        .rr_ptr_o   (rr_ptr)
`ifdef REG_LOCK_PERF_EN
        ,
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_locks();
        logic [63:0] v;
        for (int r = 0; r < 64; r++) v[r] = m_lock[r];
        return v;
    endfunction

    // Scan from the priority pointer; a requester is blocked if any register
    // it wants is still held and not being released this cycle.
    function automatic int model_winner();
        int w;
        w = -1;
        if (flush) return -1;
        for (int k = 0; k < N; k++) begin
            int  i;
            bit  blocked;
            i = (m_ptr + k) % N;
            blocked = 0;
            for (int r = 0; r < 64; r++) begin
                if (ls[i][r] && m_lock[r] && !unlock[r]) blocked = 1;
            end
            if (w < 0 && req[i] && !blocked) w = i;
        end
        return w;
    endfunction

    task automatic model_update(input int w);
        int nreq;
        nreq = 0;
        for (int i = 0; i < N; i++) nreq += int'(req[i]);
        if (!flush && (nreq >= 2 || (nreq > 0 && w < 0)) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (flush) begin
            for (int r = 0; r < 64; r++) m_lock[r] = 0;
        end else begin
            for (int r = 0; r < 64; r++) begin
                if (unlock[r]) m_lock[r] = 0;
                if (w >= 0 && ls[w][r]) m_lock[r] = 1;
            end
            if (w >= 0) m_ptr = (w + 1) % N;
        end
        m_lock[0] = 0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 64; r++) m_lock[r] = 0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // Inputs are set just after a posedge; grant sampled at negedge, state after next posedge.
    task automatic run_cycle();
        int w;
        logic [N-1:0] eg;
        w  = model_winner();
        eg = (w >= 0) ? N'(1 << w) : '0;
        @(negedge clk);
        obs_gnt = gnt;
        chk("gnt", {60'b0, gnt}, {60'b0, eg});
        @(posedge clk);
        model_update(w);
        #1;
        chk("locks", locks, model_locks());
        chk("rr_ptr", {62'b0, rr_ptr}, 64'(m_ptr));
`ifdef REG_LOCK_PERF_EN
        chk("conflict_cnt", {32'b0, conflict_cnt}, m_cnt);
`endif
    endtask

    task automatic idle_inputs();
        req    = '0;
        unlock = '0;
        flush  = 1'b0;
        for (int i = 0; i < N; i++) ls[i] = '0;
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        model_reset();
        idle_inputs();
        req = 4'b1111;
        ls[0] = 64'h2;
        #1;
        chk("reset_gnt", {60'b0, gnt}, 64'h0);
        chk("reset_locks", locks, 64'h0);
        chk("reset_ptr", {62'b0, rr_ptr}, 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] RR_GNT [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        arst_n = 1'b0;
        idle_inputs();
        apply_reset();

        // Idle after reset
        repeat (3) run_cycle();

        // Round-robin fairness
        for (int c = 0; c < 5; c++) begin
            logic [63:0] prev_set;
            prev_set = (c == 0) ? 64'h0 : ls[$clog2(RR_GNT[(c+4)%5])];
            req = 4'b1111;
            for (int i = 0; i < N; i++) ls[i] = 64'(1) << (i + 1);
            unlock = prev_set;
            chk("rr_ptr_before", {62'b0, rr_ptr}, 64'(c % 4));
            run_cycle();
            chk("rr_gnt", {60'b0, obs_gnt}, {60'b0, RR_GNT[c]});
        end

        // Clear, then park the pointer at 0 with bit 5 locked by requester 3
        idle_inputs(); flush = 1'b1; run_cycle();
        idle_inputs(); req = 4'b1000; ls[3] = 64'h20; run_cycle();
        chk("waw_setup", locks, 64'h20);

        // WAW blocking
        idle_inputs(); req = 4'b0011; ls[0] = 64'h20; ls[1] = 64'h40;
        run_cycle();
        chk("waw_gnt", {60'b0, obs_gnt}, 64'b0010);
        chk("waw_locks", locks, 64'h60);

        // Unlock and re-lock of the same register in one cycle
        idle_inputs(); req = 4'b0100; ls[2] = 64'h80; run_cycle();
        idle_inputs(); req = 4'b0100; ls[2] = 64'h80; unlock = 64'h80;
        run_cycle();
        chk("same_cyc_gnt", {60'b0, obs_gnt}, 64'b0100);
        chk("same_cyc_bit7", {63'b0, locks[7]}, 64'h1);

        // Flush priority
        idle_inputs(); flush = 1'b1; run_cycle();
        idle_inputs(); req = 4'b0001; ls[0] = 64'hF0; run_cycle();
        chk("flush_setup", locks, 64'hF0);
        begin
            logic [1:0] p;
            p = rr_ptr;
            idle_inputs(); flush = 1'b1; req = 4'b1111;
            for (int i = 0; i < N; i++) ls[i] = 64'(1) << (i + 8);
            run_cycle();
            chk("flush_gnt", {60'b0, obs_gnt}, 64'h0);
            chk("flush_locks", locks, 64'h0);
            chk("flush_ptr", {62'b0, rr_ptr}, {62'b0, p});
        end

        // x0 immunity
        idle_inputs(); req = 4'b0001; ls[0] = 64'h1;
        run_cycle();
        chk("x0_gnt", {60'b0, obs_gnt}, 64'b0001);
        chk("x0_bit0", {63'b0, locks[0]}, 64'h0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                ls[i] = 64'(1) << $urandom_range(0, 12);
                if ($urandom_range(0, 3) == 0) ls[i] |= 64'(1) << $urandom_range(0, 12);
            end
            unlock = 64'($urandom_range(0, 8191)) & 64'($urandom);
            flush  = ($urandom_range(0, 19) == 0);
            run_cycle();
        end

        // Asynchronous reset in the middle of a cycle drops every lock at once
        idle_inputs(); req = 4'b0011; ls[0] = 64'h300; ls[1] = 64'hC00; run_cycle();
        arst_n = 1'b0;
        #1;
        chk("async_rst_locks", locks, 64'h0);
        chk("async_rst_ptr", {62'b0, rr_ptr}, 64'h0);
        apply_reset();

`ifdef REG_LOCK_PERF_EN
        for (int c = 0; c < 10; c++) begin
            idle_inputs(); req = 4'b0011; ls[0] = 64'(1) << (c + 1); ls[1] = 64'(1) << (c + 20);
            run_cycle();
        end
        chk("perf_10", {32'b0, conflict_cnt}, 64'd10);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
